// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS ID/EX stage: ALU control codes, ALUOp and funct values.
package mips_pkg;

  // ALU control codes understood by MIPS_ALU; only these seven may ever be produced
  localparam logic [3:0] ALUCT_AND = 4'b0000;
  localparam logic [3:0] ALUCT_OR  = 4'b0001;
  localparam logic [3:0] ALUCT_ADD = 4'b0010;
  localparam logic [3:0] ALUCT_SUB = 4'b0110;
  localparam logic [3:0] ALUCT_SLT = 4'b0111;
  localparam logic [3:0] ALUCT_NOR = 4'b1100;
  localparam logic [3:0] ALUCT_XOR = 4'b1101;

  // ALUOp as produced by the main decoder
  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ORI    = 2'b11
  } aluop_t;

  // Supported R-type funct fields
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_XOR = 6'b100110;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/mips_alu_ctrl.sv
// Combinational ALU-control decoder: {aluop, funct} -> {aluct, illegal}.
// Unsupported R-type functs fall back to ADD so the ALU never sees an unknown code.
module mips_alu_ctrl
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] aluct,
  output logic       illegal
);

  // Decode ALUOp first; only the R-type class consults funct
  always_comb begin
    aluct   = ALUCT_ADD;
    illegal = 1'b0;
    case (aluop)
      ALUOP_MEM:    aluct = ALUCT_ADD;
      ALUOP_BRANCH: aluct = ALUCT_SUB;
      ALUOP_ORI:    aluct = ALUCT_OR;
      default: begin
        case (funct)
          FUNCT_ADD: aluct = ALUCT_ADD;
          FUNCT_SUB: aluct = ALUCT_SUB;
          FUNCT_AND: aluct = ALUCT_AND;
          FUNCT_OR:  aluct = ALUCT_OR;
          FUNCT_XOR: aluct = ALUCT_XOR;
          FUNCT_NOR: aluct = ALUCT_NOR;
          FUNCT_SLT: aluct = ALUCT_SLT;
          default: begin
            aluct   = ALUCT_ADD;
            illegal = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/mips_id_ex_stage.sv
// ID/EX pipeline register with execute-stage operand front end.
// Flow control: id_valid marks a real instruction in ID; each edge the register
// either bubbles (flush, or load-use hazard when not stalled), holds (stall), or
// captures ID with ex_valid=id_valid. ld_use_hazard tells upstream to hold PC/IF-ID.
module mips_id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_aluop,
  input  logic [5:0]    id_funct,
  input  logic          id_alusrc,
  input  logic          id_regdst,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          stall,
  input  logic          flush,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic          ld_use_hazard,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [3:0]    ex_aluct,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dest,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          ex_illegal
);

  logic [3:0]    id_aluct;
  logic          id_illegal;

  logic [DW-1:0] rs_data_q, rt_data_q, imm_q;
  logic [RW-1:0] rs_q, rt_q, dest_q;
  logic [3:0]    aluct_q;
  logic          valid_q, illegal_q, alusrc_q;
  logic          regwrite_q, memread_q, memwrite_q, memtoreg_q;
  logic [DW-1:0] fwd_rt;

  mips_alu_ctrl u_alu_ctrl (
    .aluop   (id_aluop),
    .funct   (id_funct),
    .aluct   (id_aluct),
    .illegal (id_illegal)
  );

  // Load-use: a load in EX whose destination is read by the instruction in ID
  always_comb begin
    ld_use_hazard = id_valid & valid_q & memread_q & (dest_q != '0) &
                    ((dest_q == id_rs) | (dest_q == id_rt));
  end

  // ID/EX register: flush > stall > hazard bubble > capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      dest_q     <= '0;
      aluct_q    <= ALUCT_AND;
      illegal_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (flush || (!stall && ld_use_hazard)) begin
      valid_q    <= 1'b0;
      illegal_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      rs_q       <= id_rs;
      rt_q       <= id_rt;
      dest_q     <= id_regdst ? id_rd : id_rt;
      aluct_q    <= id_aluct;
      illegal_q  <= id_valid & id_illegal;
      alusrc_q   <= id_alusrc;
      // an illegal R-type must never write the register file
      regwrite_q <= id_valid & id_regwrite & ~id_illegal;
      memread_q  <= id_valid & id_memread;
      memwrite_q <= id_valid & id_memwrite;
      memtoreg_q <= id_valid & id_memtoreg;
    end
  end

  // Operand A: EX/MEM beats MEM/WB; $0 is never forwarded
  always_comb begin
    if (exmem_regwrite && (exmem_rd == rs_q) && (rs_q != '0))
      ex_a = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rs_q) && (rs_q != '0))
      ex_a = memwb_result;
    else
      ex_a = rs_data_q;
  end

  // Forwarded rt feeds both operand B and the store data path
  always_comb begin
    if (exmem_regwrite && (exmem_rd == rt_q) && (rt_q != '0))
      fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rt_q) && (rt_q != '0))
      fwd_rt = memwb_result;
    else
      fwd_rt = rt_data_q;
  end

  // Output drive: operand B select and valid-gated controls
  always_comb begin
    ex_b          = alusrc_q ? imm_q : fwd_rt;
    ex_store_data = fwd_rt;
    ex_valid      = valid_q;
    ex_aluct      = aluct_q;
    ex_dest       = dest_q;
    ex_illegal    = illegal_q;
    ex_regwrite   = valid_q & regwrite_q;
    ex_memread    = valid_q & memread_q;
    ex_memwrite   = valid_q & memwrite_q;
    ex_memtoreg   = valid_q & memtoreg_q;
  end

endmodule

// File: tb/tb_mips_id_ex_stage.sv
// Directed bench for mips_id_ex_stage with hand-computed expectations.
module tb_mips_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        stall, flush;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        ld_use_hazard, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_aluct;
  logic [4:0]  ex_dest;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_illegal;

  int checks = 0;
  int errors = 0;

  mips_id_ex_stage #(.DW(32), .RW(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_aluop(id_aluop), .id_funct(id_funct),
    .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .stall(stall), .flush(flush),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .ld_use_hazard(ld_use_hazard), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_aluct(ex_aluct), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg), .ex_illegal(ex_illegal)
  );

  // clock and reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge, then sample away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0;
    id_rs = 0; id_rt = 0; id_rd = 0; id_aluop = 2'b00; id_funct = 0;
    id_alusrc = 0; id_regdst = 0; id_regwrite = 0; id_memread = 0;
    id_memwrite = 0; id_memtoreg = 0; stall = 0; flush = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic drive_rtype(input logic [5:0] f, input logic [4:0] rs, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [31:0] rsd, input logic [31:0] rtd);
    id_valid = 1; id_aluop = 2'b10; id_funct = f; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_regdst = 1; id_regwrite = 1; id_alusrc = 0;
    id_memread = 0; id_memwrite = 0; id_memtoreg = 0;
  endtask

  task automatic drive_lw(input logic [4:0] rt);
    id_valid = 1; id_aluop = 2'b00; id_funct = 0; id_rs = 5'd2; id_rt = rt; id_rd = 0;
    id_rs_data = 32'h100; id_rt_data = 0; id_imm = 32'h4; id_regdst = 0; id_regwrite = 1;
    id_alusrc = 1; id_memread = 1; id_memwrite = 0; id_memtoreg = 1;
  endtask

  logic [5:0] functs [7];
  logic [3:0] codes  [7];

  initial begin
    functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010};
    codes  = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b1101, 4'b1100, 4'b0111};
    clear_id();
    rst_n = 0;
    #1;
    check("reset_valid", ex_valid, 0);
    check("reset_regwrite", ex_regwrite, 0);
    check("reset_aluct", ex_aluct, 4'b0000);
    check("reset_dest", ex_dest, 0);
    check("reset_illegal", ex_illegal, 0);
    check("reset_memread", ex_memread, 0);
    @(posedge clk); #1 rst_n = 1;

    // R-type sweep rs=5 rt=3 rd=7
    for (int i = 0; i < 7; i++) begin
      drive_rtype(functs[i], 5'd5, 5'd3, 5'd7, 32'h11, 32'h22);
      step();
      check($sformatf("rtype_aluct_%0d", i), ex_aluct, codes[i]);
      check($sformatf("rtype_illegal_%0d", i), ex_illegal, 0);
      check($sformatf("rtype_regwrite_%0d", i), ex_regwrite, 1);
    end
    check("rtype_dest", ex_dest, 7);
    check("rtype_a", ex_a, 32'h11);
    check("rtype_b", ex_b, 32'h22);

    // unsupported funct
    drive_rtype(6'b000000, 5'd5, 5'd3, 5'd7, 32'h11, 32'h22);
    step();
    check("illegal_aluct", ex_aluct, 4'b0010);
    check("illegal_flag", ex_illegal, 1);
    check("illegal_regwrite", ex_regwrite, 0);
    check("illegal_valid", ex_valid, 1);

    // non-R ALUOp classes
    id_aluop = 2'b00; step(); check("aluop00", ex_aluct, 4'b0010); check("aluop00_illegal", ex_illegal, 0);
    id_aluop = 2'b01; step(); check("aluop01", ex_aluct, 4'b0110);
    id_aluop = 2'b11; step(); check("aluop11", ex_aluct, 4'b0001);

    // forwarding on rs=4 and rt=6
    drive_rtype(6'b100000, 5'd4, 5'd6, 5'd9, 32'h1111, 32'h2222);
    step();
    exmem_regwrite = 1; exmem_rd = 4; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 4; memwb_result = 32'h5555;
    #1 check("fwd_both_exmem_wins", ex_a, 32'hAAAA);
    check("fwd_rt_none", ex_b, 32'h2222);
    exmem_regwrite = 0;
    #1 check("fwd_memwb", ex_a, 32'h5555);
    memwb_regwrite = 0;
    #1 check("fwd_none", ex_a, 32'h1111);
    memwb_regwrite = 1; memwb_rd = 6; memwb_result = 32'h6666;
    #1 check("fwd_rt_b", ex_b, 32'h6666);
    check("fwd_rt_store", ex_store_data, 32'h6666);
    exmem_regwrite = 1; exmem_rd = 6; exmem_result = 32'h7777;
    #1 check("fwd_rt_exmem", ex_store_data, 32'h7777);
    exmem_regwrite = 0; memwb_regwrite = 0;

    // $0 never forwarded
    drive_rtype(6'b100000, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0);
    step();
    exmem_regwrite = 1; exmem_rd = 0; exmem_result = 32'hFFFF;
    memwb_regwrite = 1; memwb_rd = 0; memwb_result = 32'hEEEE;
    #1 check("zero_no_fwd_a", ex_a, 32'h0);
    check("zero_no_fwd_b", ex_b, 32'h0);
    exmem_regwrite = 0; memwb_regwrite = 0;

    // immediate operand
    drive_rtype(6'b100000, 5'd1, 5'd3, 5'd9, 32'h5, 32'h33);
    id_alusrc = 1; id_imm = 32'hFFFFFFF0;
    step();
    check("imm_b", ex_b, 32'hFFFFFFF0);
    check("imm_store", ex_store_data, 32'h33);

    // load-use: lw $8 in EX, add rs=8 in ID
    drive_lw(5'd8);
    step();
    check("lw_dest", ex_dest, 8);
    check("lw_memread", ex_memread, 1);
    check("lw_memtoreg", ex_memtoreg, 1);
    check("lw_b_imm", ex_b, 32'h4);
    drive_rtype(6'b100000, 5'd8, 5'd9, 5'd10, 32'h100, 32'h200);
    #1 check("lu_hazard", ld_use_hazard, 1);
    step();
    check("lu_bubble_valid", ex_valid, 0);
    check("lu_bubble_regwrite", ex_regwrite, 0);
    check("lu_bubble_memread", ex_memread, 0);
    check("lu_hazard_clear", ld_use_hazard, 0);
    step();
    check("lu_capture_valid", ex_valid, 1);
    check("lu_capture_dest", ex_dest, 10);
    check("lu_capture_a", ex_a, 32'h100);
    check("lu_capture_regwrite", ex_regwrite, 1);

    // stall alone 3 cycles holds everything
    drive_rtype(6'b100010, 5'd1, 5'd2, 5'd11, 32'h999, 32'h888);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("stall_valid_%0d", i), ex_valid, 1);
      check($sformatf("stall_dest_%0d", i), ex_dest, 10);
      check($sformatf("stall_aluct_%0d", i), ex_aluct, 4'b0010);
      check($sformatf("stall_a_%0d", i), ex_a, 32'h100);
      check($sformatf("stall_b_%0d", i), ex_b, 32'h200);
    end
    stall = 0;
    step();
    check("unstall_dest", ex_dest, 11);
    check("unstall_aluct", ex_aluct, 4'b0110);

    // hazard asserts under stall but stall holds the load in EX
    drive_lw(5'd12);
    step();
    drive_rtype(6'b100000, 5'd3, 5'd12, 5'd13, 32'h1, 32'h2);
    stall = 1;
    #1 check("stall_hazard", ld_use_hazard, 1);
    step();
    check("stall_over_hazard_valid", ex_valid, 1);
    check("stall_over_hazard_memread", ex_memread, 1);

    // stall and flush same edge -> bubble
    flush = 1;
    step();
    check("flush_valid", ex_valid, 0);
    check("flush_memread", ex_memread, 0);
    check("flush_memtoreg", ex_memtoreg, 0);
    stall = 0; flush = 0;
    step();
    check("post_flush_valid", ex_valid, 1);
    check("post_flush_dest", ex_dest, 13);

    // asynchronous reset mid-run
    #2 rst_n = 0;
    #1 check("async_valid", ex_valid, 0);
    check("async_regwrite", ex_regwrite, 0);
    check("async_aluct", ex_aluct, 4'b0000);
    rst_n = 1;
    drive_rtype(6'b100111, 5'd3, 5'd4, 5'd14, 32'h1, 32'h2);
    step();
    check("after_reset_valid", ex_valid, 1);
    check("after_reset_aluct", ex_aluct, 4'b1100);
    check("after_reset_dest", ex_dest, 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
